// File: rtl/psp_mem_pkg.sv
// Shared types and defaults for the PSP two-master memory arbiter.
package psp_mem_pkg;

   localparam int DEFAULT_TIMEOUT = 64;
   localparam int PSP_ADDR_W      = 32;
   localparam int PSP_DATA_W      = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_t;

   typedef struct packed {
      logic                    read;
      logic                    write;
      logic [PSP_ADDR_W-1:0]   addr;
      logic [PSP_DATA_W-1:0]   wdata;
      logic [PSP_DATA_W/8-1:0] wmask;
   } mem_req_t;

endpackage

// File: rtl/psp_arb_watchdog.sv
// Hang detector for one memory transaction: counts stalled cycles and flags
// expire when TIMEOUT_CYCLES is reached (TIMEOUT_CYCLES = 0 never expires).
module psp_arb_watchdog
   import psp_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_q;

   // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clear)
         count_q <= '0;
      else if (enable && (count_q != LIMIT))
         count_q <= count_q + CNT_W'(1);
   end

   assign expire = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/psp_mem_arbiter.sv
// Shares the single PSP memory port between instruction fetch (I) and
// load/store (D). Define PSP_ARB_RR_EN for alternating grants on contention.
module psp_mem_arbiter
   import psp_mem_pkg::*;
#(
   parameter int ADDR_W         = PSP_ADDR_W,
   parameter int DATA_W         = PSP_DATA_W,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_resp,
   output logic                i_err,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_resp,
   output logic                d_err,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_resp,
   output logic                grant_d
);

   localparam int MASK_W = DATA_W / 8;

   arb_state_t state_q;
   mem_req_t   req_q;
   logic       d_req;
   logic       pick_d;
   logic       serving;
   logic       expire;
   logic       finish;

   assign d_req   = d_read | d_write;
   assign serving = (state_q != IDLE);
   // Reset in the same cycle as a response swallows it: the transaction is dropped.
   assign finish  = serving & (mem_resp | expire) & ~reset;

`ifdef PSP_ARB_RR_EN
   owner_t last_owner_q;
`endif

   // NOTE: pick_d gets a default before any branch so no latch is inferred.
   always_comb begin
      pick_d = d_req;
`ifdef PSP_ARB_RR_EN
      if (d_req && i_read)
         pick_d = (last_owner_q == OWNER_I);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (d_req || i_read) begin
                  if (pick_d) begin
                     // Illegal read+write collapses to a write.
                     state_q     <= SERVE_D;
                     req_q.read  <= d_read & ~d_write;
                     req_q.write <= d_write;
                     req_q.addr  <= PSP_ADDR_W'(d_addr);
                     req_q.wdata <= PSP_DATA_W'(d_wdata);
                     req_q.wmask <= (PSP_DATA_W/8)'(d_wmask);
                  end else begin
                     state_q     <= SERVE_I;
                     req_q.read  <= 1'b1;
                     req_q.write <= 1'b0;
                     req_q.addr  <= PSP_ADDR_W'(i_addr);
                     req_q.wdata <= '0;
                     req_q.wmask <= '0;
                  end
               end
            end
            default: begin
               if (finish) begin
                  state_q <= IDLE;
                  req_q   <= '0;
               end
            end
         endcase
      end
   end

`ifdef PSP_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset)
         last_owner_q <= OWNER_I;
      else if ((state_q == IDLE) && (d_req || i_read))
         last_owner_q <= pick_d ? OWNER_D : OWNER_I;
   end
`endif

   psp_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (~serving),
      .enable (serving & ~mem_resp),
      .expire (expire)
   );

   assign mem_read  = req_q.read;
   assign mem_write = req_q.write;
   assign mem_addr  = ADDR_W'(req_q.addr);
   assign mem_wdata = DATA_W'(req_q.wdata);
   assign mem_wmask = MASK_W'(req_q.wmask);
   assign grant_d   = (state_q == SERVE_D);

   // A real response beats a same-cycle timeout, so err only flags a pure abort.
   assign i_resp  = finish & (state_q == SERVE_I);
   assign d_resp  = finish & (state_q == SERVE_D);
   assign i_err   = i_resp & ~mem_resp;
   assign d_err   = d_resp & ~mem_resp;
   assign i_rdata = (i_resp & mem_resp) ? mem_rdata : '0;
   assign d_rdata = (d_resp & mem_resp) ? mem_rdata : '0;

endmodule

// File: doc/psp_mem_arbiter.md
Name: psp_mem_arbiter

Overview:
Two-master arbiter that shares the PSP's single memory port between the instruction-fetch port (I) and the load/store port (D). It sits between the core and the memory model/BRAM.
- Latches one winning request at a time and holds the memory-side request stable until the memory responds.
- Routes the response back to the winner only.
- A watchdog aborts memory transactions that hang.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (DATA_W/8 byte-mask bits)
TIMEOUT_CYCLES, 64, cycles in SERVE without mem_resp before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_read  in  1  I-port read request, level, held until i_resp
i_addr  in  ADDR_W  I-port address
i_rdata  out  DATA_W  I-port read data, valid with i_resp
i_resp  out  1  I-port one-cycle completion pulse
i_err  out  1  I-port timeout flag, qualified by i_resp
d_read  in  1  D-port read request
d_write  in  1  D-port write request
d_addr  in  ADDR_W  D-port address
d_wdata  in  DATA_W  D-port write data
d_wmask  in  DATA_W/8  D-port byte enables
d_rdata  out  DATA_W  D-port read data
d_resp  out  1  D-port completion pulse
d_err  out  1  D-port timeout flag
mem_read  out  1  memory read strobe, held until mem_resp
mem_write  out  1  memory write strobe, held until mem_resp
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid with mem_resp
mem_resp  in  1  memory completion pulse
grant_d  out  1  debug: 1 while D is the current owner

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Reset values: state=IDLE; all mem_* = 0; all *_resp, *_err, *_rdata = 0; grant_d = 0; watchdog counter = 0.
- Arbitration in IDLE, sampled at the clock edge:
  - d_read|d_write alone -> SERVE_D.
  - i_read alone -> SERVE_I.
  - Both requesting -> fixed priority, D wins.
  - Neither -> stay in IDLE.
- On grant, the registered copies of addr/wdata/wmask/op are latched. mem_* are driven from these latches in the following cycle, so the arbiter adds one cycle of request latency.
- If d_read and d_write are both asserted, this is illegal; the write wins and no read is issued.
- In SERVE_x: mem_read/mem_write stay asserted and stable until mem_resp. Changes on the granted requester's inputs are ignored, because the latched request completes.
- On mem_resp in SERVE_x:
  - x_resp=1 and x_rdata=mem_rdata in the same cycle, combinational pass-through.
  - The other port's resp stays 0 and its rdata holds 0.
  - mem_* drop next cycle; state -> IDLE.
- There is one mandatory IDLE cycle between transactions. Back-to-back throughput is 1 transaction per (mem latency + 2) cycles.
- mem_resp outside SERVE is ignored.
- Watchdog:
  - The counter clears on entry to SERVE and increments each SERVE cycle without mem_resp.
  - When it reaches TIMEOUT_CYCLES: x_resp=1, x_err=1, x_rdata=0; mem_* deassert; state -> IDLE.
  - mem_resp arriving in the same cycle as the timeout takes precedence, so err=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1). There is no wrap, because it saturates at the abort.
- A reset asserted during SERVE forces IDLE next edge. The outstanding transaction is dropped with no resp to either port, and mem_* go to 0.
- Starvation: under fixed priority a continuously requesting D can starve I indefinitely. This is accepted without PSP_ARB_RR_EN.

Optional Feature:
PSP_ARB_RR_EN
- Defined:
  - A 1-bit last_owner register is added (reset value I).
  - On simultaneous requests in IDLE, grant goes to the port that did not own the previous transaction.
  - A lone requester is always granted.
  - I waits at most one D transaction.
- Undefined: fixed D-over-I priority as described above.

Decomposition:
- A shared package psp_mem_pkg holds:
  - an arb_state_t enum (IDLE, SERVE_I, SERVE_D);
  - an owner_t enum (OWNER_I, OWNER_D);
  - a mem_req_t struct {read, write, addr, wdata, wmask};
  - the localparam DEFAULT_TIMEOUT = 64.
- One sub-module, psp_arb_watchdog: counter with clear/enable inputs, TIMEOUT_CYCLES parameter, and a single expire output.

Test Plan:
- Reset release, I reads 0x0000_0040, memory answers 2 cycles after mem_read with 0xDEADBEEF -> mem_read rises 1 cycle after i_read; i_resp=1 and i_rdata=0xDEADBEEF in the mem_resp cycle; d_resp stays 0.
- Simultaneous d_write(addr 0x100, wdata 0x12345678, wmask 0xF) and i_read(0x44) -> D served first with the mem_write fields exact; one IDLE cycle; then mem_read at 0x44 and i_resp.
- Continuous d_read plus i_read:
  - without PSP_ARB_RR_EN, I gets no grant over 10 transactions;
  - with it, grants alternate D, I, D, I.
- Memory never responds, TIMEOUT_CYCLES=8 -> d_resp=1 and d_err=1 exactly 8 cycles after mem_read asserts; mem_* then 0; next request served normally with err=0.
- Reset asserted for 1 cycle mid-SERVE_I -> no i_resp; mem_read=0 next cycle; a fresh i_read completes correctly.
- Granted requester changes d_addr mid-transaction -> mem_addr keeps the latched value until mem_resp.
